// File: rtl/multicycle_control.sv
// Multicycle datapath control FSM (Moore) for a MIPS-style subset:
// R-type, lw, sw, beq, j, addi. Unsupported opcodes flag IllegalOp in DECODE
// and return to FETCH. Memory states wait on MemReady without any timeout.
//
// Ports:
//   Clock, Reset      single clock; synchronous active-high reset to FETCH
//   OpCode[5:0]       instruction bits [31:26] from the instruction register
//   MemReady          memory access completes this cycle when high
//   PCWrite .. RegDst single-bit datapath controls
//   ALUOp[1:0]        00 add, 01 sub, 10 funct-decoded
//   ALUSrcB[1:0]      00 B, 01 const 4, 10 sign-ext imm, 11 shifted imm
//   PCSource[1:0]     00 ALU result, 01 ALUOut, 10 jump target
//   IllegalOp         one-cycle unsupported-opcode flag (DECODE only)
//   State[3:0]        current state encoding, for debug
module multicycle_control (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [5:0] OpCode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemToReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRd    = 4'd3,
    StMemWb    = 4'd4,
    StMemWr    = 4'd5,
    StRtExec   = 4'd6,
    StRtWb     = 4'd7,
    StBeq      = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  state_e state_q, state_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  assign State = state_q;

  always_comb begin
    state_d     = StFetch;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    IllegalOp   = 1'b0;

    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // IR load and PC+4 only happen once the fetch read actually completes
        IRWrite = MemReady;
        PCWrite = MemReady;
        state_d = MemReady ? StDecode : StFetch;
      end
      StDecode: begin
        ALUSrcB = 2'b11;
        unique case (OpCode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StRtExec;
          OpBeq:      state_d = StBeq;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiExec;
          default: begin
            state_d   = StFetch;
            IllegalOp = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        // IR is frozen outside FETCH, so re-reading OpCode here is safe
        state_d = (OpCode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = MemReady ? StMemWb : StMemRd;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        state_d  = StFetch;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = MemReady ? StFetch : StMemWr;
      end
      StRtExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = StRtWb;
      end
      StRtWb: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StBeq: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_d     = StFetch;
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = StFetch;
      end
      StAddiExec: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      // encodings 12-15: all outputs stay 0, recover to FETCH
      default: state_d = StFetch;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       Clock;
  logic       Reset;
  logic [5:0] OpCode;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, IllegalOp;
  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .OpCode      (OpCode),
    .MemReady    (MemReady),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemToReg    (MemToReg),
    .IRWrite     (IRWrite),
    .ALUSrcA     (ALUSrcA),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .ALUOp       (ALUOp),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .IllegalOp   (IllegalOp),
    .State       (State)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Control word order:
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemToReg,IRWrite,ALUSrcA,RegWrite,RegDst,
  //  ALUOp[1:0],ALUSrcB[1:0],PCSource[1:0],IllegalOp}
  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rdst;
    logic [1:0] aluop, srcb, pcsrc;
    logic       ill;
  } ctrl_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
  } vec_t;

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  // Per-state control table written straight from the state descriptions.
  function automatic ctrl_t exp_ctrl(input int st, input logic rdy, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (st)
      0:  begin c.mrd = 1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; end
      1:  begin c.srcb = 2'b11; c.ill = !legal(op); end
      2:  begin c.srca = 1; c.srcb = 2'b10; end
      3:  begin c.mrd = 1; c.iord = 1; end
      4:  begin c.rw = 1; c.m2r = 1; end
      5:  begin c.mwr = 1; c.iord = 1; end
      6:  begin c.srca = 1; c.aluop = 2'b10; end
      7:  begin c.rdst = 1; c.rw = 1; end
      8:  begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; end
      9:  begin c.pcw = 1; c.pcsrc = 2'b10; end
      10: begin c.srca = 1; c.srcb = 2'b10; end
      11: begin c.rw = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Drive one cycle's inputs (called at negedge), check outputs, advance to next negedge.
  task automatic step(input logic rst, input logic [5:0] op, input logic rdy,
                      input int exp_st, input string name);
    ctrl_t act, exp;
    Reset = rst; OpCode = op; MemReady = rdy;
    #1;
    act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA,
           RegWrite, RegDst, ALUOp, ALUSrcB, PCSource, IllegalOp};
    exp = exp_ctrl(exp_st, rdy, op);
    checks++;
    if (State !== exp_st[3:0]) begin
      errors++;
      $display("FAIL %s state: got %0d want %0d", name, State, exp_st);
    end
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ctrl (state %0d): got %h want %h", name, State, act, exp);
    end
    checks++;
    if ((MemRead & MemWrite) !== 1'b0 || (RegWrite & IRWrite) !== 1'b0) begin
      errors++;
      $display("FAIL %s exclusivity: got mrd/mwr=%b%b rw/irw=%b%b want no overlap",
               name, MemRead, MemWrite, RegWrite, IRWrite);
    end
    @(negedge Clock);
  endtask

  // Reference model: expected state path of one instruction from FETCH, built from
  // the per-opcode routes, with fst fetch stalls and mst memory stalls.
  // abort_at >= 0 asserts Reset on that cycle and ends the instruction there.
  task automatic run_instr(input logic [5:0] op, input int fst, input int mst,
                           input int abort_at, input string name);
    int   sts[$];
    logic rdys[$];
    for (int i = 0; i < fst; i++) begin sts.push_back(0); rdys.push_back(1'b0); end
    sts.push_back(0); rdys.push_back(1'b1);
    sts.push_back(1); rdys.push_back(1'($urandom));
    case (op)
      6'b100011, 6'b101011: begin
        int w;
        w = (op == 6'b100011) ? 3 : 5;
        sts.push_back(2); rdys.push_back(1'($urandom));
        for (int i = 0; i < mst; i++) begin sts.push_back(w); rdys.push_back(1'b0); end
        sts.push_back(w); rdys.push_back(1'b1);
        if (op == 6'b100011) begin sts.push_back(4); rdys.push_back(1'($urandom)); end
      end
      6'b000000: begin
        sts.push_back(6); rdys.push_back(1'($urandom));
        sts.push_back(7); rdys.push_back(1'($urandom));
      end
      6'b000100: begin sts.push_back(8); rdys.push_back(1'($urandom)); end
      6'b000010: begin sts.push_back(9); rdys.push_back(1'($urandom)); end
      6'b001000: begin
        sts.push_back(10); rdys.push_back(1'($urandom));
        sts.push_back(11); rdys.push_back(1'($urandom));
      end
      default: ;
    endcase
    for (int i = 0; i < sts.size(); i++) begin
      step(i == abort_at, op, rdys[i], sts[i], name);
      if (i == abort_at) break;
    end
  endtask

  vec_t tbl[$];
  logic [5:0] ops[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

  initial begin
    Reset = 1'b1; OpCode = '0; MemReady = 1'b0;
    @(posedge Clock); @(posedge Clock); @(negedge Clock);

    // reset state, R-type path, illegal op, reset in MEMWR stall, jump, beq, reset priority
    tbl.push_back('{1'b1, 6'h00, 1'b0, 4'd0});
    tbl.push_back('{1'b0, 6'h00, 1'b1, 4'd0});
    tbl.push_back('{1'b0, 6'h00, 1'b1, 4'd1});
    tbl.push_back('{1'b0, 6'h00, 1'b1, 4'd6});
    tbl.push_back('{1'b0, 6'h00, 1'b1, 4'd7});
    tbl.push_back('{1'b0, 6'h00, 1'b1, 4'd0});
    tbl.push_back('{1'b0, 6'h3F, 1'b1, 4'd1});
    tbl.push_back('{1'b0, 6'h3F, 1'b0, 4'd0});
    tbl.push_back('{1'b0, 6'h2B, 1'b1, 4'd0});
    tbl.push_back('{1'b0, 6'h2B, 1'b1, 4'd1});
    tbl.push_back('{1'b0, 6'h2B, 1'b1, 4'd2});
    tbl.push_back('{1'b0, 6'h2B, 1'b0, 4'd5});
    tbl.push_back('{1'b1, 6'h2B, 1'b0, 4'd5});
    tbl.push_back('{1'b0, 6'h2B, 1'b1, 4'd0});
    tbl.push_back('{1'b0, 6'h02, 1'b1, 4'd1});
    tbl.push_back('{1'b0, 6'h02, 1'b1, 4'd9});
    tbl.push_back('{1'b0, 6'h04, 1'b1, 4'd0});
    tbl.push_back('{1'b0, 6'h04, 1'b1, 4'd1});
    tbl.push_back('{1'b0, 6'h04, 1'b1, 4'd8});
    tbl.push_back('{1'b1, 6'h04, 1'b1, 4'd0});
    tbl.push_back('{1'b0, 6'h04, 1'b0, 4'd0});
    tbl.push_back('{1'b0, 6'h04, 1'b1, 4'd0});
    tbl.push_back('{1'b1, 6'h23, 1'b1, 4'd1});
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].op, tbl[i].rdy, int'(tbl[i].st), $sformatf("vec%0d", i));
    end

    // multi-cycle corner cases
    run_instr(6'b100011, 0, 3, -1, "lw_mem_stall");
    run_instr(6'b101011, 2, 0, -1, "sw_fetch_stall");
    run_instr(6'b000100, 0, 0, -1, "beq");
    run_instr(6'b000010, 0, 0, -1, "j");
    run_instr(6'b001000, 0, 0, -1, "addi");
    run_instr(6'b111111, 1, 0, -1, "illegal");
    run_instr(6'b100011, 0, 4, 5, "lw_reset_in_memrd");
    run_instr(6'b000000, 0, 0, -1, "rtype_after_reset");

    // randomized instruction stream with occasional reset aborts
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      int fst, mst, ab;
      op  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      fst = $urandom_range(0, 3);
      mst = $urandom_range(0, 4);
      ab  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, fst + 3) : -1;
      run_instr(op, fst, mst, ab, $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
